// File: rtl/fifo4_pkg.sv
// Shared sizing constants and helpers for the 4-entry FIFO write bank.
package fifo4_pkg;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam int CNT_W = 3;

  localparam logic [CNT_W-1:0] FULL_CNT  = 3'd4;
  localparam logic [CNT_W-1:0] EMPTY_CNT = 3'd0;

  // One-hot decode of a pointer into per-entry write strobes.
  function automatic logic [DEPTH-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    ptr_dec    = '0;
    ptr_dec[p] = 1'b1;
  endfunction

endpackage

// File: rtl/fifo4_ptr.sv
// Wrapping PTR_W-bit pointer with increment enable and async active-low clear.
module fifo4_ptr
  import fifo4_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Next pointer: advance by one, natural wrap at 2**PTR_W.
  always_comb begin
    ptr_d = ptr_q;
    if (en_i) ptr_d = ptr_q + PTR_W'(1);
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo4_write_bank.sv
// Write side of the 4-entry FIFO: write demux into four entry registers,
// read/write pointers, occupancy, full/empty flags and sticky error flags.
// The head word is selected downstream by an external 4:1 mux on rd_sel.
module fifo4_write_bank
  import fifo4_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] q0,
  output logic [DATA_W-1:0] q1,
  output logic [DATA_W-1:0] q2,
  output logic [DATA_W-1:0] q3,
  output logic [PTR_W-1:0]  rd_sel,
  output logic              rd_en,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              ovf_err,
  output logic              udf_err
);

  logic [DEPTH-1:0][DATA_W-1:0] ent_q;
  logic [DEPTH-1:0]             wr_stb;
  logic [PTR_W-1:0]             wr_ptr;
  logic [PTR_W-1:0]             rd_ptr;
  logic [CNT_W-1:0]             count_q, count_d;
  logic                         ovf_q, ovf_d;
  logic                         udf_q, udf_d;
  logic                         push_ok, pop_ok;

  // Flags come straight from registered occupancy.
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == EMPTY_CNT);

  // A push into a full FIFO is allowed only when a pop frees the head slot
  // in the same cycle; a pop on empty is never satisfied (no din bypass).
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop);

  fifo4_ptr u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (push_ok),
    .ptr_o (wr_ptr)
  );

  fifo4_ptr u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (pop_ok),
    .ptr_o (rd_ptr)
  );

  // Write demux: only the entry addressed by wr_ptr is strobed.
  always_comb begin
    wr_stb = '0;
    if (push_ok) wr_stb = ptr_dec(wr_ptr);
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    // Entry register: loads din on its strobe, otherwise holds. When full
    // with push&&pop the strobed slot is also the head, so the reader still
    // sees the old word this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         ent_q[g] <= '0;
      else if (wr_stb[g]) ent_q[g] <= din;
    end
  end

  // Occupancy and sticky error next-state.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q | (push && full && !pop);
    udf_d = udf_q | (pop && empty);
  end

  // Occupancy and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= EMPTY_CNT;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign q0      = ent_q[0];
  assign q1      = ent_q[1];
  assign q2      = ent_q[2];
  assign q3      = ent_q[3];
  assign rd_sel  = rd_ptr;
  assign rd_en   = pop_ok;
  assign count   = count_q;
  assign ovf_err = ovf_q;
  assign udf_err = udf_q;

endmodule
